// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the unified memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } arb_src_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side bundle of the arbiter
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side: takes requests and read data, drives grants, responses and the memory bus
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Core and memory side: the mirror image of the arbiter
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// rtl/mem_port_arbiter_prio.sv - data-first winner select with fetch starvation guard
module arb_prio import mem_arb_pkg::*; #(
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     if_req,
  input  logic     d_req,
  input  logic     pick,
  output arb_src_t winner
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));

  // Data wins ties unless fetch has already lost STARVE_MAX times in a row
  always_comb begin
    winner = SRC_D;
    if (if_req && (!d_req || starved)) begin
      winner = SRC_IF;
    end
  end

  // Count data wins taken over a waiting fetch; only a real pick in IDLE moves it
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pick && (if_req || d_req)) begin
      if (winner == SRC_IF) begin
        starve_cnt <= '0;
      end else if (if_req && !starved) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int LW = 3;

  arb_state_t    state;
  arb_src_t      winner;
  arb_src_t      pick_src;
  logic [LW-1:0] lat_cnt;

  arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk    (clk),
    .rst    (rst),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .pick   (state == IDLE),
    .winner (pick_src)
  );

  // Access sequencer: every output is registered and set on the transition into its state
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      winner        <= SRC_IF;
      lat_cnt       <= '0;
      bus.if_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= {DATA_W{1'b0}};
      bus.d_gnt     <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= {DATA_W{1'b0}};
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.busy      <= 1'b0;
    end else begin
      bus.if_gnt    <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.mem_en    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            state      <= ISSUE;
            winner     <= pick_src;
            bus.busy   <= 1'b1;
            bus.mem_en <= 1'b1;
            if (pick_src == SRC_IF) begin
              bus.if_gnt    <= 1'b1;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= {DATA_W{1'b0}};
            end else begin
              bus.d_gnt     <= 1'b1;
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
            end
          end
        end
        ISSUE: begin
          // mem_we still holds the winner's direction here; a store needs no response
          bus.mem_we <= 1'b0;
          if (bus.mem_we) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            state   <= WAIT;
            lat_cnt <= LW'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LW'(1);
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            if (winner == SRC_IF) begin
              bus.if_rdata  <= bus.mem_rdata;
              bus.if_rvalid <= 1'b1;
            end else begin
              bus.d_rdata  <= bus.mem_rdata;
              bus.d_rvalid <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port unified memory between two requesters: the instruction-fetch path (driven by the program counter) and the load/store data path (driven by the ALU result and control). It replaces the separate instruction and data memory instances in the core. It sequences every access through a small FSM with a per-port request/grant/response handshake. A `busy` output lets the core stall while an access is in flight.

## Interface
- `ADDR_W`, 32, address width of all ports
- `DATA_W`, 32, data width of all ports
- `MEM_LAT`, 1, cycles from the memory issue cycle to valid `mem_rdata`; legal range 1..8
- `STARVE_MAX`, 4, number of consecutive data wins over a pending fetch before fetch is forced to win

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  reset, synchronous and active-high
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch granted, one-cycle pulse
- `if_rvalid`  out  1  fetch data valid, one-cycle pulse
- `if_rdata`  out  DATA_W  fetched instruction
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data granted, one-cycle pulse
- `d_rvalid`  out  1  load data valid, one-cycle pulse; never asserted for stores
- `d_rdata`  out  DATA_W  load data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid MEM_LAT cycles after the `mem_en` cycle
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- **States:** IDLE, ISSUE, WAIT.
- **IDLE:** requests are sampled only in this state.
  - No request: stay in IDLE.
  - Otherwise pick a winner and go to ISSUE.
- **ISSUE:** lasts exactly one cycle.
  - Outputs: `mem_en`=1, `mem_addr`/`mem_we`/`mem_wdata` from the winner, and the winner's `gnt`=1.
  - Fetch always drives `mem_we`=0 and `mem_wdata`=0.
  - Store: next state is IDLE.
  - Load or fetch: next state is WAIT with the counter loaded to MEM_LAT−1.
- **WAIT:** `mem_en`=0.
  - While the counter ≠ 0, decrement it.
  - When the counter = 0, capture `mem_rdata` into the winner's `rdata` register, pulse its `rvalid` in the next cycle, and go to IDLE.
- **Priority:**
  - Data beats fetch when both are requesting.
  - Exception: if the starvation counter = STARVE_MAX and `if_req`=1, fetch wins.
- **Starvation counter:**
  - Increments, saturating at STARVE_MAX, whenever data wins while `if_req`=1.
  - Clears to 0 when fetch wins.
  - Holds its value otherwise.
- **Requester rule:** a requester deasserts `req` in the cycle after its `gnt`, unless it is presenting a new request. Request inputs in ISSUE and WAIT are ignored.
- **Address handling:** addresses pass through unmodified; no alignment checks.
- **Output registers:** `if_rdata`/`d_rdata` hold their last captured value until the next capture for that port.

## Timing
- **Reset values** (`rst` sampled high at an edge): state=IDLE, counter=0, starvation counter=0. Every output is 0 in the following cycle, including both `rdata` registers and `busy`.
- **Reset mid-operation:** the access is abandoned and no `rvalid` is produced. A store whose ISSUE cycle has already occurred is committed.
- **Load or fetch latency:** with the request present in cycle 0, the sequence is:
  - ISSUE in cycle 1
  - WAIT in cycles 2..1+MEM_LAT
  - `rvalid` in cycle 2+MEM_LAT; the FSM is in IDLE in that same cycle.
- **Store latency:** ISSUE in cycle 1, IDLE in cycle 2. The next request can issue in cycle 3.
- **Back-to-back:** a request present in the `rvalid` cycle issues in the following cycle.
- **`busy`:** equals (state ≠ IDLE). It is registered, so it does not cover cycle 0.

## Structure
- **Shared package `mem_arb_pkg`:**
  - `arb_state_t` enum: IDLE, ISSUE, WAIT
  - `arb_src_t` enum: SRC_IF, SRC_D
  - default ADDR_W/DATA_W constants
- **Sub-module `arb_prio`:** holds the starvation counter and the winner select. Inputs: `if_req`, `d_req`, a `pick` strobe asserted in IDLE. Output: winner as `arb_src_t`.
- **Top level:** FSM, latency counter, winner register and output registers.

## Test plan
All scenarios use MEM_LAT=1 and STARVE_MAX=4 unless stated.
- **Reset:** hold `rst` for 2 cycles with random inputs → all outputs 0 and `busy`=0 in the cycle after reset.
- **Single fetch:** `if_addr`=0x00000010, memory model returns 0x00500093 →
  - cycle 1: `if_gnt`=1, `mem_en`=1, `mem_we`=0, `mem_addr`=0x10
  - cycle 3: `if_rvalid`=1, `if_rdata`=0x00500093
  - `d_rvalid` remains 0 throughout.
- **Store:** `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF →
  - cycle 1: `mem_we`=1 for exactly one cycle, `busy` high for one cycle
  - no `d_rvalid`
  - a following load from 0x100 returns 0xDEADBEEF.
- **Starvation:** `if_req` and `d_req` both held high continuously → grant order D, D, D, D, IF, D…; `if_addr` appears on `mem_addr` on the fifth grant.
- **Reset in WAIT:** assert `rst` in cycle 2 of a load → no `d_rvalid`, all outputs 0 in cycle 3, and a new `if_req` issues normally afterwards.
- **MEM_LAT=3:** fetch request in cycle 0 → `busy` high in cycles 1..4, `if_rvalid` in cycle 5 carrying the `mem_rdata` value present in cycle 4.
